llc_arbiter: RTL and testbench
==============================

Name: llc_arbiter

Overview:
- Shares the single last-level line port (the burst cacheline adaptor toward memory) between the instruction cache and the data cache.
- Accepts whole-line read requests from the I-cache and line read/write-back requests from the D-cache, and serializes them one at a time.
- Latches the winning request and drives it downstream, then routes the one-cycle completion back to the winner.
- Sits between the split L1 caches and the cacheline adaptor.

Parameters:
ADDR_W, 32, address width of all ports
LINE_W, 256, cache line width in bits
RR_EN, 1, 1 = round-robin on simultaneous requests; 0 = fixed priority, D-cache wins

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
i_read  in  1  I-cache line read request, held until i_resp
i_addr  in  ADDR_W  I-cache line address
i_rdata  out  LINE_W  line returned to I-cache
i_resp  out  1  one-cycle completion pulse to I-cache
d_read  in  1  D-cache line read request, held until d_resp
d_write  in  1  D-cache line write-back request, held until d_resp
d_addr  in  ADDR_W  D-cache line address
d_wdata  in  LINE_W  D-cache write-back line
d_rdata  out  LINE_W  line returned to D-cache
d_resp  out  1  one-cycle completion pulse to D-cache
mem_read  out  1  read request to line port
mem_write  out  1  write request to line port
mem_addr  out  ADDR_W  line address to line port, bits [4:0] forced to 0
mem_wdata  out  LINE_W  write line to line port
mem_rdata  in  LINE_W  line from line port, valid with mem_resp
mem_resp  in  1  line port completion pulse
grant  out  2  {d_owner, i_owner}, one-hot or zero; for perf counters

Behaviour:
- Reset (async, any state): state=IDLE, last_grant=D, all latches cleared; i_resp, d_resp, mem_read, mem_write, grant, mem_addr and mem_wdata are all 0. Any downstream transaction in flight is abandoned; the line port is reset by the same rst.
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- IDLE, D only (d_read|d_write): latch d_addr, d_wdata and op (write if d_write, else read) -> SERVE_D.
- IDLE, I only: latch i_addr and op=read -> SERVE_I.
- IDLE, both requesting, RR_EN=1: grant the side opposite last_grant. RR_EN=0: grant D.
- IDLE, no request: stay.
- Grant write: last_grant updates when the grant is taken.
- d_read and d_write both high (illegal): treated as write.
- SERVE_x outputs: mem_read/mem_write driven from the latched op, held continuously until mem_resp. mem_addr and mem_wdata come from the latches and stay stable for the whole transaction. grant bit for the owner is 1.
- Requester inputs changing during SERVE are ignored.
- SERVE_x on mem_resp=1: assert x_resp for exactly that cycle (combinational from mem_resp & state) -> RELEASE.
- RELEASE (1 cycle): all mem_* requests low, grant=0, no resp. The served requester drops its request here. The other requester's pending request is evaluated in the following IDLE cycle -> IDLE.
- Latency: request visible in IDLE at cycle n gives mem_read/mem_write high at n+1. The requester sees resp in the same cycle as mem_resp. Minimum back-to-back spacing is 2 idle cycles between consecutive downstream transactions (RELEASE + IDLE).
- i_rdata = d_rdata = mem_rdata continuously. It is only meaningful with the matching resp.
- mem_resp in IDLE or RELEASE: ignored, no resp generated.
- Requester protocol: a requester must not drop its request before resp. If it does, the latched transaction still completes and its resp pulse is still issued.
- No starvation with RR_EN=1: under continuous dual requests, grants alternate I, D, I, D…

Test Plan:
- Reset with i_read=1 held: no outputs until rst falls; first IDLE cycle grants I. mem_read=1 and mem_addr=0x0000_1040 the next cycle; mem_resp with mem_rdata=pattern A -> i_resp=1 for one cycle, i_rdata=A.
- D write-back alone: d_write=1, d_addr=0x8000_0123, d_wdata=B -> mem_write=1, mem_addr=0x8000_0120, mem_wdata=B stable until mem_resp; d_resp one cycle; then mem_write=0 in RELEASE.
- Simultaneous i_read and d_read, RR_EN=1, after reset: I served first, then D. With both held continuously for 4 transactions, grant sequence is I, D, I, D.
- Same stimulus with RR_EN=0: D served first and on every tie.
- Stray mem_resp pulse in IDLE: no i_resp or d_resp. Change d_addr mid-SERVE_D: mem_addr unchanged.
- Assert rst during SERVE_D with mem_write high: mem_write=0 and grant=0 immediately (asynchronously). After release, pending requests are re-arbitrated from IDLE.

Source files
------------

// File: rtl/llc_arbiter_if.sv
// Bundle of the I-cache, D-cache and line-port signals that meet at the
// last-level line arbiter. The master view belongs to the arbiter and the
// slave view to everything around it (both L1 caches and the line port).
interface llc_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    // I-cache side
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    // D-cache side
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    // line port side
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;
    // {d_owner, i_owner}
    logic [1:0]        grant;

    modport master (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata,
        input  mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
        output mem_read, mem_write, mem_addr, mem_wdata, grant
    );

    modport slave (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata,
        output mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  mem_read, mem_write, mem_addr, mem_wdata, grant
    );
endinterface

// File: rtl/llc_arbiter.sv
// Shares the single cacheline port between the I-cache and the D-cache.
// One whole-line transaction at a time: the winner's request is latched,
// driven downstream until mem_resp, and the completion pulse is routed back.
// Ties go round-robin (RR_EN=1) or always to the D-cache (RR_EN=0).
module llc_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int RR_EN  = 1
) (
    input  logic          clk,
    input  logic          rst,
    llc_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // line addresses always start on a 32-byte boundary
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(32'h1f);

    state_t            state_reg, state_next;
    logic              last_d_reg;      // 1: most recent grant went to the D-cache
    logic              op_write_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [LINE_W-1:0] wdata_reg;

    logic              d_req;
    logic              i_req;
    logic              tie_to_d;
    logic [1:0]        owner;           // {d_owner, i_owner}
    logic [1:0]        resp_vec;

    // a simultaneous read+write from the D-cache counts as a write-back
    assign d_req    = bus.d_read | bus.d_write;
    assign i_req    = bus.i_read;
    // on a tie the D-cache wins when fixed priority is selected or when I went last
    assign tie_to_d = (RR_EN == 0) || !last_d_reg;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // capture the winning request and remember who won, at the moment of grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d_reg   <= 1'b1;
            op_write_reg <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
        end else if (state_reg == IDLE && state_next == SERVE_D) begin
            last_d_reg   <= 1'b1;
            op_write_reg <= bus.d_write;
            addr_reg     <= bus.d_addr & LINE_MASK;
            wdata_reg    <= bus.d_wdata;
        end else if (state_reg == IDLE && state_next == SERVE_I) begin
            last_d_reg   <= 1'b0;
            op_write_reg <= 1'b0;
            addr_reg     <= bus.i_addr & LINE_MASK;
        end
    end

    // next-state: arbitrate in IDLE, wait for mem_resp while serving, one RELEASE cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (d_req && (!i_req || tie_to_d)) begin
                    state_next = SERVE_D;
                end else if (i_req) begin
                    state_next = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.mem_resp) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // outputs: downstream request strobes and owner vector from the current state
    always_comb begin
        owner         = 2'b00;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        case (state_reg)
            SERVE_I: begin
                owner        = 2'b01;
                bus.mem_read = 1'b1;
            end
            SERVE_D: begin
                owner         = 2'b10;
                bus.mem_read  = !op_write_reg;
                bus.mem_write = op_write_reg;
            end
            default: begin
                owner = 2'b00;
            end
        endcase
    end

    // per-requester grant and completion; completion only while that side owns the port
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign bus.grant[gi] = owner[gi];
            assign resp_vec[gi]  = owner[gi] & bus.mem_resp;
        end
    endgenerate

    assign bus.i_resp    = resp_vec[0];
    assign bus.d_resp    = resp_vec[1];
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.i_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_llc_arbiter.sv
// Bench for llc_arbiter: two instances (round-robin and fixed priority) share
// the same stimulus; a transaction-level model per instance predicts owner,
// strobes, address/data and completions from the arbitration rules.
module tb_llc_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;
    localparam int NONE = 0;
    localparam int SIDE_I = 1;
    localparam int SIDE_D = 2;

    logic clk;
    logic rst;

    llc_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus0 ();
    llc_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus1 ();

    llc_arbiter #(.ADDR_W(AW), .LINE_W(LW), .RR_EN(1)) u_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    llc_arbiter #(.ADDR_W(AW), .LINE_W(LW), .RR_EN(0)) u_fixed (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // fixed-priority instance sees exactly the same inputs
    assign bus1.i_read    = bus0.i_read;
    assign bus1.i_addr    = bus0.i_addr;
    assign bus1.d_read    = bus0.d_read;
    assign bus1.d_write   = bus0.d_write;
    assign bus1.d_addr    = bus0.d_addr;
    assign bus1.d_wdata   = bus0.d_wdata;
    assign bus1.mem_rdata = bus0.mem_rdata;
    assign bus1.mem_resp  = bus0.mem_resp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    typedef struct packed {
        logic          rst;
        logic          i_read;
        logic          d_read;
        logic          d_write;
        logic [AW-1:0] i_addr;
        logic [AW-1:0] d_addr;
        logic [LW-1:0] d_wdata;
        logic          mem_resp;
        logic [LW-1:0] mem_rdata;
        logic          mem_read;
        logic          mem_write;
        logic [AW-1:0] mem_addr;
        logic [LW-1:0] mem_wdata;
        logic [LW-1:0] i_rdata;
        logic [LW-1:0] d_rdata;
        logic          i_resp;
        logic          d_resp;
        logic [1:0]    grant;
    } obs_t;

    obs_t obs0, obs1;
    assign obs0 = {rst, bus0.i_read, bus0.d_read, bus0.d_write, bus0.i_addr, bus0.d_addr,
                   bus0.d_wdata, bus0.mem_resp, bus0.mem_rdata, bus0.mem_read, bus0.mem_write,
                   bus0.mem_addr, bus0.mem_wdata, bus0.i_rdata, bus0.d_rdata, bus0.i_resp,
                   bus0.d_resp, bus0.grant};
    assign obs1 = {rst, bus1.i_read, bus1.d_read, bus1.d_write, bus1.i_addr, bus1.d_addr,
                   bus1.d_wdata, bus1.mem_resp, bus1.mem_rdata, bus1.mem_read, bus1.mem_write,
                   bus1.mem_addr, bus1.mem_wdata, bus1.i_rdata, bus1.d_rdata, bus1.i_resp,
                   bus1.d_resp, bus1.grant};

    // reference model state, one slot per instance
    int            m_owner [2];
    bit            m_cool  [2];
    int            m_last  [2];
    bit            m_opw   [2];
    logic [AW-1:0] m_addr  [2];
    logic [LW-1:0] m_wdata [2];
    logic [1:0]    m_prev_grant [2];
    logic [1:0]    gq0 [$];
    logic [1:0]    gq1 [$];

    task automatic model_step(input int k, input bit rr, input obs_t o);
        logic [5:0] ctl_got;
        logic [5:0] ctl_exp;
        bit dq, iq;
        int win;
        ctl_got = {o.mem_read, o.mem_write, o.grant, o.i_resp, o.d_resp};
        if (o.rst) begin
            check_eq($sformatf("u%0d rst_ctl", k), LW'(ctl_got), LW'(6'd0));
            check_eq($sformatf("u%0d rst_addr", k), LW'(o.mem_addr), LW'(1'b0));
            check_eq($sformatf("u%0d rst_wdata", k), o.mem_wdata, LW'(1'b0));
            m_owner[k] = NONE;
            m_cool[k]  = 1'b0;
            m_last[k]  = SIDE_D;
            m_prev_grant[k] = 2'b00;
            return;
        end
        case (m_owner[k])
            SIDE_I:  ctl_exp = {1'b1, 1'b0, 2'b01, o.mem_resp, 1'b0};
            SIDE_D:  ctl_exp = {!m_opw[k], m_opw[k], 2'b10, 1'b0, o.mem_resp};
            default: ctl_exp = 6'd0;
        endcase
        check_eq($sformatf("u%0d ctl", k), LW'(ctl_got), LW'(ctl_exp));
        if (o.grant != 2'b00 && m_prev_grant[k] == 2'b00) begin
            if (k == 0) gq0.push_back(o.grant);
            else        gq1.push_back(o.grant);
        end
        m_prev_grant[k] = o.grant;
        if (m_owner[k] != NONE) begin
            check_eq($sformatf("u%0d mem_addr", k), LW'(o.mem_addr), LW'(m_addr[k]));
            if (m_owner[k] == SIDE_D) begin
                check_eq($sformatf("u%0d mem_wdata", k), o.mem_wdata, m_wdata[k]);
            end
            if (o.mem_resp) begin
                if (m_owner[k] == SIDE_I) check_eq($sformatf("u%0d i_rdata", k), o.i_rdata, o.mem_rdata);
                else                      check_eq($sformatf("u%0d d_rdata", k), o.d_rdata, o.mem_rdata);
                m_owner[k] = NONE;
                m_cool[k]  = 1'b1;
            end
        end else if (m_cool[k]) begin
            m_cool[k] = 1'b0;
        end else begin
            dq = o.d_read | o.d_write;
            iq = o.i_read;
            if (dq && iq)  win = (rr && m_last[k] == SIDE_D) ? SIDE_I : SIDE_D;
            else if (dq)   win = SIDE_D;
            else if (iq)   win = SIDE_I;
            else           win = NONE;
            if (win == SIDE_D) begin
                m_addr[k]  = o.d_addr & ~32'h1f;
                m_wdata[k] = o.d_wdata;
                m_opw[k]   = o.d_write;
            end else if (win == SIDE_I) begin
                m_addr[k]  = o.i_addr & ~32'h1f;
                m_opw[k]   = 1'b0;
            end
            m_owner[k] = win;
            if (win != NONE) m_last[k] = win;
        end
    endtask

    // model both instances every cycle, mid-cycle
    always @(negedge clk) begin
        model_step(0, 1'b1, obs0);
        model_step(1, 1'b0, obs1);
    end

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [LW-1:0] line_a;
    logic [LW-1:0] line_b;
    logic [1:0]    exp_rr [4];
    logic          busy;
    logic          ir, dr;
    int            sel;

    initial begin
        line_a = {8{32'hCAFE_0A0A}};
        line_b = {4{64'h0123_4567_89AB_CDEF}};
        exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01; exp_rr[3] = 2'b10;

        // reset with I-cache request already held
        rst = 1'b1;
        bus0.i_read = 1'b1; bus0.i_addr = 32'h0000_1040;
        bus0.d_read = 1'b0; bus0.d_write = 1'b0;
        bus0.d_addr = '0;   bus0.d_wdata = '0;
        bus0.mem_resp = 1'b0; bus0.mem_rdata = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        check_eq("first_read", LW'(bus0.mem_read), LW'(1'b1));
        check_eq("first_addr", LW'(bus0.mem_addr), LW'(32'h0000_1040));
        check_eq("first_grant", LW'(bus0.grant), LW'(2'b01));
        tick();
        bus0.mem_resp = 1'b1; bus0.mem_rdata = line_a;
        @(negedge clk);
        check_eq("i_resp_pulse", LW'(bus0.i_resp), LW'(1'b1));
        check_eq("i_rdata_a", bus0.i_rdata, line_a);
        tick();
        bus0.mem_resp = 1'b0; bus0.i_read = 1'b0;
        @(negedge clk);
        check_eq("i_resp_drop", LW'(bus0.i_resp), LW'(1'b0));
        check_eq("release_read", LW'(bus0.mem_read), LW'(1'b0));

        // lone D-cache write-back, address changes mid-transaction
        tick();
        bus0.d_write = 1'b1; bus0.d_addr = 32'h8000_0123; bus0.d_wdata = line_b;
        tick();
        @(negedge clk);
        check_eq("wb_write", LW'(bus0.mem_write), LW'(1'b1));
        check_eq("wb_addr", LW'(bus0.mem_addr), LW'(32'h8000_0120));
        check_eq("wb_wdata", bus0.mem_wdata, line_b);
        tick();
        bus0.d_addr = 32'h1234_5678; bus0.d_wdata = ~line_b;
        @(negedge clk);
        check_eq("wb_addr_hold", LW'(bus0.mem_addr), LW'(32'h8000_0120));
        check_eq("wb_wdata_hold", bus0.mem_wdata, line_b);
        tick();
        bus0.mem_resp = 1'b1;
        @(negedge clk);
        check_eq("d_resp_pulse", LW'(bus0.d_resp), LW'(1'b1));
        tick();
        bus0.mem_resp = 1'b0; bus0.d_write = 1'b0;
        @(negedge clk);
        check_eq("wb_release", LW'(bus0.mem_write), LW'(1'b0));
        check_eq("d_resp_drop", LW'(bus0.d_resp), LW'(1'b0));

        // stray completion while idle
        tick();
        tick();
        bus0.mem_resp = 1'b1;
        @(negedge clk);
        check_eq("stray_resp", LW'({bus0.i_resp, bus0.d_resp}), LW'(2'b00));
        tick();
        bus0.mem_resp = 1'b0;

        // continuous dual reads from reset: RR alternates, fixed always D
        rst = 1'b1;
        tick();
        gq0.delete();
        gq1.delete();
        tick();
        rst = 1'b0;
        bus0.i_read = 1'b1; bus0.d_read = 1'b1;
        for (int c = 0; c < 80 && gq0.size() < 4; c++) begin
            @(negedge clk);
            busy = bus0.mem_read | bus0.mem_write;
            tick();
            bus0.mem_resp = busy && !bus0.mem_resp;
        end
        bus0.i_read = 1'b0; bus0.d_read = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            busy = bus0.mem_read | bus0.mem_write;
            tick();
            bus0.mem_resp = busy && !bus0.mem_resp;
        end
        bus0.mem_resp = 1'b0;
        check_eq("rr_count", LW'(gq0.size()), LW'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < gq0.size()) check_eq($sformatf("rr_seq%0d", i), LW'(gq0[i]), LW'(exp_rr[i]));
            if (i < gq1.size()) check_eq($sformatf("fix_seq%0d", i), LW'(gq1[i]), LW'(2'b10));
        end

        // asynchronous reset during a write-back
        tick();
        tick();
        bus0.d_write = 1'b1; bus0.d_addr = 32'h4000_0040; bus0.d_wdata = line_a;
        tick();
        @(negedge clk);
        check_eq("pre_rst_write", LW'(bus0.mem_write), LW'(1'b1));
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_write", LW'(bus0.mem_write), LW'(1'b0));
        check_eq("async_grant", LW'(bus0.grant), LW'(2'b00));
        check_eq("async_addr", LW'(bus0.mem_addr), LW'(1'b0));
        tick();
        bus0.i_read = 1'b1; bus0.i_addr = 32'h0000_2000;
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        check_eq("rearb_rr", LW'(bus0.grant), LW'(2'b01));
        check_eq("rearb_fixed", LW'(bus1.grant), LW'(2'b10));

        // randomized traffic, requesters hold until their completion
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            ir = bus0.i_resp;
            dr = bus0.d_resp;
            tick();
            bus0.mem_resp  = ($urandom_range(0, 2) == 0);
            bus0.mem_rdata = rand_line();
            if (bus0.i_read) begin
                if (ir) bus0.i_read = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                bus0.i_read = 1'b1;
                bus0.i_addr = $urandom;
            end
            if (bus0.d_read || bus0.d_write) begin
                if (dr) begin
                    bus0.d_read = 1'b0; bus0.d_write = 1'b0;
                end else if ($urandom_range(0, 5) == 0) begin
                    bus0.d_addr = $urandom; bus0.d_wdata = rand_line();
                end
            end else if ($urandom_range(0, 3) == 0) begin
                sel = $urandom_range(0, 7);
                bus0.d_read  = (sel < 4) || (sel == 7);
                bus0.d_write = (sel >= 4);
                bus0.d_addr  = $urandom;
                bus0.d_wdata = rand_line();
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
